// File: rtl/ex_pkg.sv
// Shared constants and types for the execute stage: MDU opcodes, MDU states,
// forwarding selects and ALU operation codes.
package ex_pkg;

  localparam logic [2:0] MDU_NONE  = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_MULT  = 3'b010;
  localparam logic [2:0] MDU_MFHI  = 3'b011;
  localparam logic [2:0] MDU_MFLO  = 3'b100;
  localparam logic [2:0] MDU_DIVU  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_t;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_WB  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_AND  = 2;
  localparam int ALU_OR   = 3;
  localparam int ALU_XOR  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_SLT  = 6;
  localparam int ALU_SLTU = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;

endpackage

// File: rtl/ex_stage_mdu_if.sv
// ID/EX-side bundle of the execute stage: decoded controls, operands,
// forwarding sources in, and EX results/stall out.
interface ex_stage_mdu_if #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int ALU_OP_W = 5
);
  logic                RegDst_ex;
  logic [ALU_OP_W-1:0] ALUCode_ex;
  logic                ALUSrcA_ex;
  logic                ALUSrcB_ex;
  logic [DATA_W-1:0]   Imm_ex;
  logic [DATA_W-1:0]   Sa_ex;
  logic [REG_AW-1:0]   RsAddr_ex;
  logic [REG_AW-1:0]   RtAddr_ex;
  logic [REG_AW-1:0]   RdAddr_ex;
  logic [DATA_W-1:0]   RsData_ex;
  logic [DATA_W-1:0]   RtData_ex;
  logic [DATA_W-1:0]   RegWriteData_wb;
  logic [DATA_W-1:0]   ALUResult_mem;
  logic [REG_AW-1:0]   RegWriteAddr_wb;
  logic [REG_AW-1:0]   RegWriteAddr_mem;
  logic                RegWrite_wb;
  logic                RegWrite_mem;
  logic [2:0]          MduOp_ex;
  logic [REG_AW-1:0]   RegWriteAddr_ex;
  logic [DATA_W-1:0]   ALUResult_ex;
  logic [DATA_W-1:0]   MemWriteData_ex;
  logic [DATA_W-1:0]   ALU_A;
  logic [DATA_W-1:0]   ALU_B;
  logic [DATA_W-1:0]   Hi;
  logic [DATA_W-1:0]   Lo;
  logic                Stall_ex;

  modport master (
    output RegDst_ex, ALUCode_ex, ALUSrcA_ex, ALUSrcB_ex, Imm_ex, Sa_ex,
           RsAddr_ex, RtAddr_ex, RdAddr_ex, RsData_ex, RtData_ex,
           RegWriteData_wb, ALUResult_mem, RegWriteAddr_wb, RegWriteAddr_mem,
           RegWrite_wb, RegWrite_mem, MduOp_ex,
    input  RegWriteAddr_ex, ALUResult_ex, MemWriteData_ex, ALU_A, ALU_B,
           Hi, Lo, Stall_ex
  );

  modport slave (
    input  RegDst_ex, ALUCode_ex, ALUSrcA_ex, ALUSrcB_ex, Imm_ex, Sa_ex,
           RsAddr_ex, RtAddr_ex, RdAddr_ex, RsData_ex, RtData_ex,
           RegWriteData_wb, ALUResult_mem, RegWriteAddr_wb, RegWriteAddr_mem,
           RegWrite_wb, RegWrite_mem, MduOp_ex,
    output RegWriteAddr_ex, ALUResult_ex, MemWriteData_ex, ALU_A, ALU_B,
           Hi, Lo, Stall_ex
  );
endinterface

// File: rtl/ex_stage_mdu_iter.sv
// Iterative multiply (and, with EX_MDU_DIV_EN, restoring divide) unit with
// HI/LO registers; one bit per cycle, stalls the pipeline while running.
module mdu_iter
  import ex_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo,
  output logic              o_stall
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int PW    = 2 * DATA_W;

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v,
                                            input logic sgn);
    logic signed [DATA_W-1:0] s;
    s = v;
    return (sgn && s < 0) ? -v : v;
  endfunction

  mdu_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  logic          w_signed;
  logic          w_start;
  logic          w_last;
  logic [PW-1:0] w_acc_nxt;
  logic [PW-1:0] w_prod;

  assign w_signed  = (i_op == MDU_MULT);
  assign w_last    = (r_state == ST_BUSY) && (r_cnt == CNT_W'(1));
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_prod    = r_neg ? -w_acc_nxt : w_acc_nxt;

`ifdef EX_MDU_DIV_EN
  logic              r_is_div;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_quo;
  logic [DATA_W-1:0] r_dvsr;
  logic [DATA_W:0]   w_shift;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_rem_nxt;
  logic [DATA_W-1:0] w_quo_nxt;

  assign w_start   = (i_op == MDU_MULTU) || (i_op == MDU_MULT) || (i_op == MDU_DIVU);
  assign w_shift   = {r_rem, r_quo[DATA_W-1]};
  assign w_diff    = w_shift - {1'b0, r_dvsr};
  // A zero divisor never borrows, which yields quotient all ones and
  // remainder equal to the dividend without a special case.
  assign w_rem_nxt = w_diff[DATA_W] ? w_shift[DATA_W-1:0] : w_diff[DATA_W-1:0];
  assign w_quo_nxt = {r_quo[DATA_W-2:0], ~w_diff[DATA_W]};
`else
  assign w_start   = (i_op == MDU_MULTU) || (i_op == MDU_MULT);
`endif

  // The start cycle stalls combinationally so the instruction stays in EX.
  assign o_stall = (r_state == ST_BUSY) || ((r_state == ST_IDLE) && w_start && !rst);
  assign o_hi    = r_hi;
  assign o_lo    = r_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
`ifdef EX_MDU_DIV_EN
      r_is_div <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: if (w_start) begin
          r_state <= ST_BUSY;
          r_cnt   <= CNT_W'(DATA_W);
          r_neg   <= w_signed && (i_a[DATA_W-1] ^ i_b[DATA_W-1]);
`ifdef EX_MDU_DIV_EN
          r_is_div <= (i_op == MDU_DIVU);
`endif
        end
        ST_BUSY: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_last) r_state <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && w_start) begin
      r_acc    <= '0;
      r_mcand  <= {{DATA_W{1'b0}}, mag(i_a, w_signed)};
      r_mplier <= mag(i_b, w_signed);
`ifdef EX_MDU_DIV_EN
      r_rem    <= '0;
      r_quo    <= i_a;
      r_dvsr   <= i_b;
`endif
    end else if (r_state == ST_BUSY) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
`ifdef EX_MDU_DIV_EN
      r_rem    <= w_rem_nxt;
      r_quo    <= w_quo_nxt;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_last) begin
`ifdef EX_MDU_DIV_EN
      if (r_is_div) begin
        r_hi <= w_rem_nxt;
        r_lo <= w_quo_nxt;
      end else begin
        {r_hi, r_lo} <= w_prod;
      end
`else
      {r_hi, r_lo} <= w_prod;
`endif
    end
  end
endmodule

// File: rtl/ex_stage_mdu_lib.sv
// Reused pipeline primitives: combinational ALU and 2/3-input muxes.
module alu
  import ex_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ALU_OP_W = 5
) (
  input  logic [ALU_OP_W-1:0] i_code,
  input  logic [DATA_W-1:0]   i_a,
  input  logic [DATA_W-1:0]   i_b,
  output logic [DATA_W-1:0]   o_y
);
  localparam int SHW = $clog2(DATA_W);

  logic signed [DATA_W-1:0] w_sa;
  logic signed [DATA_W-1:0] w_sb;
  logic [SHW-1:0]           w_sh;

  assign w_sa = i_a;
  assign w_sb = i_b;
  // Shifts take the amount from A (Sa) and shift B (Rt), as in MIPS SLL/SRL/SRA.
  assign w_sh = i_a[SHW-1:0];

  always_comb begin
    o_y = '0;
    case (i_code)
      ALU_OP_W'(ALU_ADD):  o_y = i_a + i_b;
      ALU_OP_W'(ALU_SUB):  o_y = i_a - i_b;
      ALU_OP_W'(ALU_AND):  o_y = i_a & i_b;
      ALU_OP_W'(ALU_OR):   o_y = i_a | i_b;
      ALU_OP_W'(ALU_XOR):  o_y = i_a ^ i_b;
      ALU_OP_W'(ALU_NOR):  o_y = ~(i_a | i_b);
      ALU_OP_W'(ALU_SLT):  o_y = {{(DATA_W-1){1'b0}}, (w_sa < w_sb)};
      ALU_OP_W'(ALU_SLTU): o_y = {{(DATA_W-1){1'b0}}, (i_a < i_b)};
      ALU_OP_W'(ALU_SLL):  o_y = i_b << w_sh;
      ALU_OP_W'(ALU_SRL):  o_y = i_b >> w_sh;
      ALU_OP_W'(ALU_SRA):  o_y = w_sb >>> w_sh;
      default:             o_y = '0;
    endcase
  end
endmodule

module mux2to1 #(
  parameter int W = 32
) (
  input  logic         i_sel,
  input  logic [W-1:0] i_d0,
  input  logic [W-1:0] i_d1,
  output logic [W-1:0] o_y
);
  assign o_y = i_sel ? i_d1 : i_d0;
endmodule

module mux3to1 #(
  parameter int W = 32
) (
  input  logic [1:0]   i_sel,
  input  logic [W-1:0] i_d0,
  input  logic [W-1:0] i_d1,
  input  logic [W-1:0] i_d2,
  output logic [W-1:0] o_y
);
  always_comb begin
    o_y = i_d0;
    case (i_sel)
      2'd1:    o_y = i_d1;
      2'd2:    o_y = i_d2;
      default: o_y = i_d0;
    endcase
  end
endmodule

// File: rtl/ex_stage_mdu.sv
// MIPS execute stage: operand forwarding, ALU, destination select and the
// iterative MDU. Optional divider enabled by defining EX_MDU_DIV_EN.
module ex_stage_mdu
  import ex_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int ALU_OP_W = 5
) (
  input  logic          clk,
  input  logic          reset,
  ex_stage_mdu_if.slave bus
);
  logic              w_a_mem, w_a_wb, w_b_mem, w_b_wb;
  logic [1:0]        w_fwd_a_sel, w_fwd_b_sel, w_res_sel;
  logic [DATA_W-1:0] w_fwd_a, w_fwd_b, w_alu_a, w_alu_b, w_alu_y;
  logic [DATA_W-1:0] w_hi, w_lo, w_result;
  logic [REG_AW-1:0] w_dst;
  logic              w_stall;

  // Register 0 is never a forwarding source; MEM is newer than WB so it wins.
  assign w_a_mem = bus.RegWrite_mem && (bus.RegWriteAddr_mem != '0) &&
                   (bus.RegWriteAddr_mem == bus.RsAddr_ex);
  assign w_a_wb  = bus.RegWrite_wb && (bus.RegWriteAddr_wb != '0) &&
                   (bus.RegWriteAddr_wb == bus.RsAddr_ex);
  assign w_b_mem = bus.RegWrite_mem && (bus.RegWriteAddr_mem != '0) &&
                   (bus.RegWriteAddr_mem == bus.RtAddr_ex);
  assign w_b_wb  = bus.RegWrite_wb && (bus.RegWriteAddr_wb != '0) &&
                   (bus.RegWriteAddr_wb == bus.RtAddr_ex);

  assign w_fwd_a_sel = w_a_mem ? FWD_MEM : (w_a_wb ? FWD_WB : FWD_REG);
  assign w_fwd_b_sel = w_b_mem ? FWD_MEM : (w_b_wb ? FWD_WB : FWD_REG);

  mux3to1 #(.W(DATA_W)) u_fwd_a (
    .i_sel(w_fwd_a_sel), .i_d0(bus.RsData_ex), .i_d1(bus.RegWriteData_wb),
    .i_d2(bus.ALUResult_mem), .o_y(w_fwd_a)
  );
  mux3to1 #(.W(DATA_W)) u_fwd_b (
    .i_sel(w_fwd_b_sel), .i_d0(bus.RtData_ex), .i_d1(bus.RegWriteData_wb),
    .i_d2(bus.ALUResult_mem), .o_y(w_fwd_b)
  );
  mux2to1 #(.W(DATA_W)) u_src_a (
    .i_sel(bus.ALUSrcA_ex), .i_d0(w_fwd_a), .i_d1(bus.Sa_ex), .o_y(w_alu_a)
  );
  mux2to1 #(.W(DATA_W)) u_src_b (
    .i_sel(bus.ALUSrcB_ex), .i_d0(w_fwd_b), .i_d1(bus.Imm_ex), .o_y(w_alu_b)
  );
  mux2to1 #(.W(REG_AW)) u_dst (
    .i_sel(bus.RegDst_ex), .i_d0(bus.RtAddr_ex), .i_d1(bus.RdAddr_ex), .o_y(w_dst)
  );

  alu #(.DATA_W(DATA_W), .ALU_OP_W(ALU_OP_W)) u_alu (
    .i_code(bus.ALUCode_ex), .i_a(w_alu_a), .i_b(w_alu_b), .o_y(w_alu_y)
  );

  // The MDU latches the forwarded register values, not the ALU operands.
  mdu_iter #(.DATA_W(DATA_W)) u_mdu (
    .clk(clk), .rst(reset), .i_op(bus.MduOp_ex), .i_a(w_fwd_a), .i_b(w_fwd_b),
    .o_hi(w_hi), .o_lo(w_lo), .o_stall(w_stall)
  );

  assign w_res_sel = (bus.MduOp_ex == MDU_MFHI) ? 2'd1 :
                     (bus.MduOp_ex == MDU_MFLO) ? 2'd2 : 2'd0;

  mux3to1 #(.W(DATA_W)) u_res (
    .i_sel(w_res_sel), .i_d0(w_alu_y), .i_d1(w_hi), .i_d2(w_lo), .o_y(w_result)
  );

  assign bus.RegWriteAddr_ex = w_dst;
  assign bus.ALUResult_ex    = w_result;
  assign bus.MemWriteData_ex = w_fwd_b;
  assign bus.ALU_A           = w_alu_a;
  assign bus.ALU_B           = w_alu_b;
  assign bus.Hi              = w_hi;
  assign bus.Lo              = w_lo;
  assign bus.Stall_ex        = w_stall;
endmodule
